// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, fetch-state encoding, default reset PC and branch-offset helper
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  function automatic logic [31:0] sext_imm4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory, decode-stage and control signals of the fetch unit
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pc;
  logic        fetch_err;
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, branch, jump, zero
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, branch, jump, zero
  );
endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: next-PC select, jump over taken branch over pc+4, all modulo 2^32
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] npc
);
  logic [31:0] w_pc4;
  logic        w_unused_op;
  assign w_pc4 = pc + 32'd4;
  assign w_unused_op = ^instr[31:26];
  assign npc = jump ? {w_pc4[31:28], instr[25:0], 2'b00}
             : (branch && zero) ? w_pc4 + sext_imm4(instr[15:0])
             : w_pc4;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: one-outstanding fetch FSM holding instr/pc until accept; FETCH_TIMEOUT_EN adds ack timeout into sticky ERR
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.master bus
);
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_npc;
  logic        w_fetch;
  logic        w_accept;
  logic        w_timeout;
  assign w_fetch  = r_state == ST_FETCH;
  assign w_accept = r_state == ST_HOLD && bus.instr_ready;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0] r_cnt;
  // counter is zero outside FETCH, so it is clear on every FETCH entry
  assign w_timeout = w_fetch && !bus.imem_ack && (r_cnt + 8'd1 == TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_cnt <= '0;
    else
      r_cnt <= (w_fetch && !bus.imem_ack) ? r_cnt + 8'd1 : '0;
  assign bus.fetch_err = r_state == ST_ERR;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else if (r_state == ST_IDLE)
      r_state <= ST_FETCH;
    else if (w_fetch && bus.imem_ack) begin
      r_instr <= bus.imem_rdata;
      r_state <= ST_HOLD;
    end else if (w_timeout)
      r_state <= ST_ERR;
    else if (w_accept) begin
      r_pc    <= w_npc;
      r_state <= ST_FETCH;
    end
  next_pc_calc u_npc (
    .pc    (r_pc),
    .instr (r_instr),
    .branch(bus.branch),
    .jump  (bus.jump),
    .zero  (bus.zero),
    .npc   (w_npc)
  );
  assign bus.imem_req    = w_fetch;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_state == ST_HOLD;
  assign bus.pc          = r_pc;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors against a cycle model of the fetch unit plus literal expectations
module tb_pc_fetch_unit;
  import mips_pkg::*;
`ifdef FETCH_TIMEOUT_EN
  localparam bit          TEN = 1'b1;
  localparam logic [7:0]  TO  = 8'd4;
`else
  localparam bit          TEN = 1'b0;
  localparam logic [7:0]  TO  = 8'd255;
`endif
  localparam logic [31:0] BEQ_M2 = {OP_BEQ, 5'd0, 5'd0, 16'hFFFE};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int m_st;
  int m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] jt [4];
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] npc_f(input logic [31:0] pc, input logic [31:0] ins,
                                       input bit b, input bit j, input bit z);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
    if (b && z) return p4 + 32'($signed(ins[15:0])) * 32'd4;
    return p4;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: 0 idle, 1 waiting for ack, 2 holding, 3 error
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_wait = 0; m_pc = 32'h0; m_instr = 32'h0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_wait = 0; end
        1: if (bus.imem_ack) begin
             m_instr = bus.imem_rdata; m_st = 2;
           end else begin
             m_wait++;
             if (TEN && m_wait == int'(TO)) m_st = 3;
           end
        2: if (bus.instr_ready) begin
             m_pc = npc_f(m_pc, m_instr, bus.branch, bus.jump, bus.zero);
             m_st = 1; m_wait = 0;
           end
        default: ;
      endcase
    end
  end
  always begin
    @(posedge clk);
    #1;
    chk("cmp_req", bus.imem_req, m_st == 1);
    chk("cmp_valid", bus.instr_valid, m_st == 2);
    chk("cmp_err", bus.fetch_err, m_st == 3);
    chk("cmp_pc", bus.pc, m_pc);
    if (m_st == 1) chk("cmp_addr", bus.imem_addr, m_pc);
    if (m_st == 2) chk("cmp_instr", bus.instr, m_instr);
  end
  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("wait_req", bus.imem_req, 1);
  endtask
  task automatic fetch(input logic [31:0] d, input int dly);
    wait_req();
    repeat (dly) @(negedge clk);
    bus.imem_ack = 1'b1; bus.imem_rdata = d;
    @(negedge clk);
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
  endtask
  task automatic accept(input bit b, input bit j, input bit z, input logic [31:0] exp_addr);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("wait_valid", bus.instr_valid, 1);
    bus.instr_ready = 1'b1; bus.branch = b; bus.jump = j; bus.zero = z;
    @(negedge clk);
    bus.instr_ready = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0; bus.zero = 1'b0;
    chk("next_addr", bus.imem_addr, exp_addr);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_err", bus.fetch_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    jt = '{32'h0FFF_FFFC, 32'h1FFF_FFFC, 32'h2FFF_FFFC, 32'h3FFF_FFFC};
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    bus.branch = 1'b0; bus.jump = 1'b0; bus.zero = 1'b0;
    @(negedge clk);
    do_reset();
    chk("idle_req", bus.imem_req, 0);
    @(negedge clk);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    fetch(32'h2008_0005, 1);
    chk("f35_valid", bus.instr_valid, 1);
    chk("f35_instr", bus.instr, 32'h2008_0005);
    accept(0, 0, 0, 32'h4);
    fetch({OP_J, 26'h4}, 0);
    accept(0, 1, 0, 32'h10);
    fetch(BEQ_M2, 0);
    accept(1, 0, 1, 32'h0C);
    fetch({OP_J, 26'h4}, 0);
    accept(0, 1, 0, 32'h10);
    fetch(BEQ_M2, 0);
    accept(1, 0, 0, 32'h14);
    for (int i = 0; i < 4; i++) begin
      fetch({OP_J, 26'h3FF_FFFF}, 0);
      accept(0, 1, 0, jt[i]);
    end
    fetch({OP_RTYPE, 26'h20}, 0);
    accept(0, 0, 0, 32'h4000_0000);
    fetch({OP_J, 26'h10}, 0);
    accept(1, 1, 1, 32'h4000_0040);
    do_reset();
    fetch(BEQ_M2, 0);
    accept(1, 0, 1, 32'hFFFF_FFFC);
    fetch({OP_LW, 26'h001_0000}, 0);
    bus.branch = 1'b1; bus.jump = 1'b1; bus.zero = 1'b1;
    repeat (5) begin
      chk("bp_instr", bus.instr, 32'h8C01_0000);
      chk("bp_pc", bus.pc, 32'hFFFF_FFFC);
      chk("bp_req", bus.imem_req, 0);
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    accept(0, 0, 0, 32'h0);
    fetch({OP_J, 26'h8}, 0);
    accept(0, 1, 0, 32'h20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_pc", bus.pc, 32'h0);
    chk("mid_req", bus.imem_req, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("stale_valid", bus.instr_valid, 0);
    chk("stale_addr", bus.imem_addr, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("stale_wait", bus.instr_valid, 0);
    end
    fetch({OP_ANDI, 26'h108_00FF}, 0);
    chk("real_instr", bus.instr, 32'h3108_00FF);
    accept(0, 0, 0, 32'h4);
`ifdef FETCH_TIMEOUT_EN
    do_reset();
    wait_req();
    repeat (3) @(negedge clk);
    chk("to_req_last", bus.imem_req, 1);
    chk("to_err_early", bus.fetch_err, 0);
    @(negedge clk);
    chk("to_err", bus.fetch_err, 1);
    chk("to_req", bus.imem_req, 0);
    bus.imem_ack = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("to_err_hold", bus.fetch_err, 1);
      chk("to_req_hold", bus.imem_req, 0);
    end
    bus.imem_ack = 1'b0;
    do_reset();
`else
    do_reset();
    wait_req();
    repeat (20) @(negedge clk);
    chk("wait_req_held", bus.imem_req, 1);
    chk("wait_no_err", bus.fetch_err, 0);
    fetch(32'h2008_0005, 0);
    chk("late_valid", bus.instr_valid, 1);
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter TIMEOUT, 8'd255: maximum wait cycles for imem_ack; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  instruction-memory fetch request, held high until acknowledged.
REQ-006 imem_addr  out  32  fetch address, equal to the PC, stable while imem_req is high.
REQ-007 imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 instr  out  32  held instruction for the control unit (opcode = instr[31:26]).
REQ-010 instr_valid  out  1  instr is valid.
REQ-011 instr_ready  in  1  decode stage accepts instr.
REQ-012 branch, jump, zero  in  1 each  control-unit Branch, Jump and ALU zero; sampled only on the accept cycle.
REQ-013 pc  out  32  PC of the instruction currently held.
REQ-014 fetch_err  out  1  sticky fetch-timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Function
REQ-015 The FSM shall have the states IDLE, FETCH, HOLD and ERR; ERR shall exist only with FETCH_TIMEOUT_EN.
REQ-016 IDLE shall last exactly one cycle after reset release, then move to FETCH.
REQ-017 In FETCH, imem_req shall be 1 and imem_addr shall equal pc.
REQ-018 imem_ack shall be honoured only while in FETCH; imem_ack in any other state shall be ignored.
REQ-019 On imem_ack in FETCH, imem_rdata shall be captured into instr and the FSM shall move to HOLD; instr_valid rises the next cycle.
REQ-020 An ack arriving in the first FETCH cycle shall be accepted, giving a minimum fetch latency of 1 cycle from req to instr_valid.
REQ-021 In HOLD, instr_valid shall be 1, and instr and pc shall be stable until accept (instr_valid && instr_ready).
REQ-022 On accept, the FSM shall return to FETCH, drop instr_valid, and load pc with next-PC.
REQ-023 Next-PC selection, with jump having priority over branch:
- jump=1: {pc4[31:28], instr[25:0], 2'b00}
- else branch=1 and zero=1: pc4 + (sign-extended instr[15:0] << 2)
- otherwise: pc4, where pc4 = pc + 4
REQ-024 All PC arithmetic shall be modulo 2^32, so pc 32'hFFFF_FFFC with no branch or jump wraps to 32'h0000_0000.
REQ-025 branch=1 with zero=0 shall yield pc4.
REQ-026 Only one fetch shall be outstanding; no new imem_req shall be issued while in HOLD.

Reset
REQ-027 Asserting rst_n low at any time shall immediately force the following, even mid-fetch or mid-hold:
- state IDLE, pc=RESET_PC, instr=0
- instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0
REQ-028 An ack from a fetch aborted by reset shall be ignored, as required by REQ-018.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, an 8-bit counter shall clear on FETCH entry and increment each FETCH cycle without ack.
REQ-030 When that counter reaches TIMEOUT, the FSM shall enter ERR, drop imem_req, and set fetch_err=1.
REQ-031 ERR shall be left only by reset.
REQ-032 Without FETCH_TIMEOUT_EN, the counter and ERR shall not exist, fetch_err shall be constant 0, and FETCH shall wait indefinitely.

Structure
REQ-033 Shared package mips_pkg shall hold the opcode constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, andi 6'b001100, j 6'b000010), the fetch-state encoding, and the default reset PC.
REQ-034 Next-PC computation shall be a separate combinational sub-module next_pc_calc, with inputs pc, instr, branch, jump, zero and output npc.

Verification
REQ-035 Reset then fetch: release rst_n, ack in the second FETCH cycle with 32'h2008_0005 -> imem_addr=0, instr_valid=1 with instr=32'h2008_0005; accept with ready -> next imem_addr=4.
REQ-036 Branch taken: pc=32'h10, instr imm=16'hFFFE, branch=1, zero=1 on accept -> next imem_addr=32'h0C; same case with zero=0 -> 32'h14.
REQ-037 Jump priority: pc=32'h4000_0000, instr[25:0]=26'h000_0010, jump=1, branch=1, zero=1 -> next imem_addr=32'h4000_0040.
REQ-038 Backpressure and wrap: hold instr_ready=0 for 5 cycles -> instr and pc stable, imem_req=0; pc=32'hFFFF_FFFC with no branch or jump -> next imem_addr=0.
REQ-039 Reset mid-fetch: rst_n low during FETCH at pc=32'h20, stale ack after release -> pc=RESET_PC, stale ack ignored, no instr_valid until the next real ack.
REQ-040 With FETCH_TIMEOUT_EN and TIMEOUT=4, withhold ack -> fetch_err=1 and imem_req=0 after 4 FETCH cycles, both held until reset.
